// File: rtl/dvi_pkg.sv
// Shared TMDS definitions for the DVI receive decoder and the matching encoder.
// Control-token constants, FSM encoding, default tuning parameters, decode payload.
package dvi_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam int unsigned SEARCH_WINDOW_DEFAULT = 4096;
    localparam int unsigned TOKEN_RUN_DEFAULT     = 16;
    localparam int unsigned SLIP_SETTLE_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } dvi_state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_word_t;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == CTRL_TOKEN_00) || (word == CTRL_TOKEN_01) ||
               (word == CTRL_TOKEN_10) || (word == CTRL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: token classification plus 8-bit data recovery.
// Data is decoded for every word; the caller decides whether it is used.
module tmds_word_decode
    import dvi_pkg::*;
(
    input  logic [9:0]  i_word,
    output tmds_word_t  o_dec_c
);

    logic [7:0] w_d;

    // Undo the optional inversion carried in bit 9.
    assign w_d = i_word[9] ? ~i_word[7:0] : i_word[7:0];

    always_comb begin
        o_dec_c          = '0;
        o_dec_c.is_token = is_ctrl_token(i_word);
        case (i_word)
            CTRL_TOKEN_01: o_dec_c.ctrl = 2'b01;
            CTRL_TOKEN_10: o_dec_c.ctrl = 2'b10;
            CTRL_TOKEN_11: o_dec_c.ctrl = 2'b11;
            default:       o_dec_c.ctrl = 2'b00;
        endcase
        // Bit 8 selects XOR or XNOR chaining of the transition-minimised byte.
        o_dec_c.data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            o_dec_c.data[i] = i_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

endmodule

// File: rtl/dvi_decoder.sv
// Per-lane TMDS receive decoder: bit-slip alignment on control tokens, then
// two-stage decode into DE, control bits and pixel byte.
module dvi_decoder
    import dvi_pkg::*;
#(
    parameter int unsigned SEARCH_WINDOW = SEARCH_WINDOW_DEFAULT,
    parameter int unsigned TOKEN_RUN     = TOKEN_RUN_DEFAULT,
    parameter int unsigned SLIP_SETTLE   = SLIP_SETTLE_DEFAULT
)(
    input  logic        I_rgb_clk,
    input  logic        I_rst_n,
    input  logic [9:0]  I_raw_word,
    output logic        O_bitslip,
    output logic        O_locked,
    output logic        O_de,
    output logic [1:0]  O_ctrl,
    output logic [7:0]  O_data
);

    localparam int unsigned GAP_W = $clog2(SEARCH_WINDOW + 1);
    localparam int unsigned RUN_W = $clog2(TOKEN_RUN + 1);
    localparam int unsigned SET_W = $clog2(SLIP_SETTLE + 1);

    dvi_state_t   r_state;
    logic [GAP_W-1:0] r_gap;
    logic [RUN_W-1:0] r_run;
    logic [SET_W-1:0] r_settle;
    logic         r_bitslip;

    logic [9:0]   r_word;
    logic         r_tok;
    logic         r_locked;
    logic         r_de;
    logic [1:0]   r_ctrl;
    logic [7:0]   r_data;

    tmds_word_t   w_dec;
    logic         w_run_done;
    logic         w_gap_done;
    logic         w_gap_sat;
    logic         w_gain_lock;
    logic         w_lose_lock;
    logic         w_lock_nxt;

    tmds_word_decode u_decode (
        .i_word  (r_word),
        .o_dec_c (w_dec)
    );

    assign w_run_done  = (r_run == RUN_W'(TOKEN_RUN - 1));
    assign w_gap_done  = (r_gap == GAP_W'(SEARCH_WINDOW - 1));
    assign w_gap_sat   = (r_gap == GAP_W'(SEARCH_WINDOW));
    assign w_gain_lock = (r_state == ST_SEARCH) && r_tok && w_run_done;
    assign w_lose_lock = (r_state == ST_LOCKED) && !r_tok && w_gap_done;
    // Lock as it will be after this edge, so gating and O_locked move together.
    assign w_lock_nxt  = w_gain_lock || ((r_state == ST_LOCKED) && !w_lose_lock);

    // Alignment FSM with gap/run counters and the bit-slip pulse.
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state   <= ST_SEARCH;
            r_gap     <= '0;
            r_run     <= '0;
            r_settle  <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_bitslip <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (r_tok) begin
                        r_gap <= '0;
                        if (r_run != RUN_W'(TOKEN_RUN)) r_run <= r_run + RUN_W'(1);
                        if (w_run_done) r_state <= ST_LOCKED;
                    end else begin
                        r_run <= '0;
                        if (!w_gap_sat) r_gap <= r_gap + GAP_W'(1);
                        if (w_gap_done) begin
                            r_state   <= ST_SLIP;
                            r_bitslip <= 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    r_gap    <= '0;
                    r_run    <= '0;
                    r_settle <= '0;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == SET_W'(SLIP_SETTLE - 1)) r_state <= ST_SEARCH;
                    else r_settle <= r_settle + SET_W'(1);
                end
                ST_LOCKED: begin
                    if (r_tok) begin
                        r_gap <= '0;
                    end else if (w_gap_done) begin
                        // Restart the window so the first slip comes a full window later.
                        r_state <= ST_SEARCH;
                        r_gap   <= '0;
                        r_run   <= '0;
                    end else if (!w_gap_sat) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

    // Stage 1 captures the raw word and token flag; stage 2 the gated decode.
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_word   <= '0;
            r_tok    <= 1'b0;
            r_locked <= 1'b0;
            r_de     <= 1'b0;
            r_ctrl   <= 2'b00;
            r_data   <= 8'h00;
        end else begin
            r_word   <= I_raw_word;
            r_tok    <= is_ctrl_token(I_raw_word);
            r_locked <= w_lock_nxt;
            if (!w_lock_nxt) begin
                r_de   <= 1'b0;
                r_ctrl <= 2'b00;
                r_data <= 8'h00;
            end else if (w_dec.is_token) begin
                r_de   <= 1'b0;
                r_ctrl <= w_dec.ctrl;
                r_data <= 8'h00;
            end else begin
                r_de   <= 1'b1;
                r_data <= w_dec.data;
            end
        end
    end

    assign O_bitslip = r_bitslip;
    assign O_locked  = r_locked;
    assign O_de      = r_de;
    assign O_ctrl    = r_ctrl;
    assign O_data    = r_data;

endmodule

// File: tb/tb_dvi_decoder.sv
// Bench for dvi_decoder: TMDS encoder model and scoreboard for decode, plus
// deserializer rotation model for bit-slip alignment and lock-loss timing.
module tb_dvi_decoder;

    localparam int unsigned W = 4096;
    localparam int unsigned S = 8;
    localparam int unsigned R = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] raw;
    logic       bitslip, locked, de;
    logic [1:0] ctrl;
    logic [7:0] data;

    dvi_decoder #(
        .SEARCH_WINDOW (W),
        .TOKEN_RUN     (R),
        .SLIP_SETTLE   (S)
    ) dut (
        .I_rgb_clk  (clk),
        .I_rst_n    (rst_n),
        .I_raw_word (raw),
        .O_bitslip  (bitslip),
        .O_locked   (locked),
        .O_de       (de),
        .O_ctrl     (ctrl),
        .O_data     (data)
    );

    always #5 clk = ~clk;

    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int disp     = 0;
    int slip_q[$];
    logic       model_on  = 1'b0;
    logic [1:0] held_ctrl = 2'b00;
    logic [9:0] prev_word = '0;
    logic [7:0] prev_byte = '0;
    logic       prev_slip = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (tok_tab[i] == w) return i;
        return -1;
    endfunction

    // Reference DVI 1.0 TMDS encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        logic       use_xnor;
        int         n1, n1q, n0q;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1q   = $countones(qm[7:0]);
        n0q   = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            q    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp = disp + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            q    = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q    = {1'b0, qm[8], qm[7:0]};
            disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
        end
    endtask

    function automatic logic [9:0] rot_word(input logic [9:0] t, input int r);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[i] = t[(i + r) % 10];
        return w;
    endfunction

    // One clock: drive a word, sample after the edge, score the word driven one step earlier.
    task automatic step(input logic [9:0] w, input logic [7:0] b);
        int ti;
        raw = w;
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip) begin
            check_val("bitslip_width", {31'b0, prev_slip}, 32'd0);
            slip_q.push_back(cyc);
        end
        if (model_on) begin
            ti = tok_idx(prev_word);
            check_val("locked_hold", {31'b0, locked}, 32'd1);
            if (ti >= 0) begin
                held_ctrl = 2'(ti);
                check_val("tok_de",   {31'b0, de},   32'd0);
                check_val("tok_ctrl", {30'b0, ctrl}, {30'b0, held_ctrl});
                check_val("tok_data", {24'b0, data}, 32'd0);
            end else begin
                check_val("dat_de",   {31'b0, de},   32'd1);
                check_val("dat_ctrl", {30'b0, ctrl}, {30'b0, held_ctrl});
                check_val("dat_data", {24'b0, data}, {24'b0, prev_byte});
            end
        end
        prev_slip = bitslip;
        prev_word = w;
        prev_byte = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] q;
        encode(b, q);
        step(q, b);
    endtask

    task automatic send_tok(input int c);
        step(tok_tab[c], 8'h00);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_bitslip"}, {31'b0, bitslip}, 32'd0);
        check_val({tag, "_locked"},  {31'b0, locked},  32'd0);
        check_val({tag, "_de"},      {31'b0, de},      32'd0);
        check_val({tag, "_ctrl"},    {30'b0, ctrl},    32'd0);
        check_val({tag, "_data"},    {24'b0, data},    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc, c0, n0, rot, budget;

        rst_n = 1'b0;
        raw   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Aligned stream: lock after 16 tokens, first gated output on the same cycle.
        for (int k = 0; k < 16; k++) send_tok(0);
        check_val("lock_early", {31'b0, locked}, 32'd0);
        send_tok(0);
        check_val("lock_rise", {31'b0, locked}, 32'd1);
        check_val("lock_first_de", {31'b0, de}, 32'd0);
        check_val("lock_first_ctrl", {30'b0, ctrl}, 32'd0);
        held_ctrl = 2'b00;
        model_on  = 1'b1;
        for (int k = 0; k < 3; k++) send_tok(0);
        step(10'b0100000000, 8'h00);

        // Control tracking, then data words holding the last control value.
        send_tok(1);
        send_tok(3);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(255)));

        // Decode sweep through the encoder model.
        disp = 0;
        for (int b = 0; b < 256; b++) send_byte(8'(b));

        // Randomised mix of tokens and data.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(3) == 0) send_tok(int'($urandom_range(3)));
            else send_byte(8'($urandom_range(255)));
        end

        // Lock loss after a full window of data words.
        send_tok(2);
        for (int k = 0; k < int'(W); k++) send_byte(8'($urandom_range(255)));
        model_on = 1'b0;
        send_byte(8'($urandom_range(255)));
        fall_cyc = cyc;
        check_val("loss_locked", {31'b0, locked}, 32'd0);
        check_val("loss_de",     {31'b0, de},     32'd0);
        check_val("loss_ctrl",   {30'b0, ctrl},   32'd0);
        check_val("loss_data",   {24'b0, data},   32'd0);
        n0 = slip_q.size();
        budget = 0;
        while (slip_q.size() == n0 && budget < int'(2 * W)) begin
            send_byte(8'($urandom_range(255)));
            budget++;
        end
        if (slip_q.size() == n0) begin
            check_val("loss_slip_seen", 32'd0, 32'd1);
        end else begin
            check_val("loss_slip_delay", 32'(slip_q[n0] - fall_cyc), W);
        end

        // Reset one cycle before the next slip would fire.
        c0 = cyc;
        while (cyc < c0 + int'(W + S)) send_byte(8'($urandom_range(255)));
        check_val("pre_rst_no_slip", 32'(slip_q.size() - n0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(posedge clk);
        #1;
        check_val("rst_edge_bitslip", {31'b0, bitslip}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = slip_q.size();
        for (int k = 0; k < 20; k++) send_byte(8'($urandom_range(255)));
        check_val("rst_no_slip", 32'(slip_q.size() - n0), 32'd0);
        for (int k = 0; k < 16; k++) send_tok(1);
        check_val("relock_early", {31'b0, locked}, 32'd0);
        send_tok(1);
        check_val("relock_rise", {31'b0, locked}, 32'd1);
        check_val("relock_ctrl", {30'b0, ctrl}, 32'd1);

        // Bit-slip alignment from rotation 3 with a tokens-only stream.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        slip_q.delete();
        rot    = 3;
        budget = 0;
        while (!locked && budget < int'(4 * (W + S + 1) + 200)) begin
            step(rot_word(tok_tab[0], rot), 8'h00);
            if (bitslip) rot = (rot + 9) % 10;
            budget++;
        end
        check_val("slip_count", 32'(slip_q.size()), 32'd3);
        check_val("slip_locked", {31'b0, locked}, 32'd1);
        for (int i = 1; i < slip_q.size(); i++) begin
            check_val("slip_spacing", {31'b0, (slip_q[i] - slip_q[i-1]) >= int'(W + S + 1)}, 32'd1);
        end
        n0 = slip_q.size();
        for (int k = 0; k < 50; k++) step(tok_tab[0], 8'h00);
        check_val("slip_after_lock", 32'(slip_q.size() - n0), 32'd0);
        check_val("slip_still_locked", {31'b0, locked}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_decoder.md
# dvi_decoder

Per-lane TMDS receive decoder for the DVI/HDMI input path, the receive-side counterpart of the per-lane TMDS encoder. It takes raw 10-bit words from an IDES10 deserializer, which can be at any bit rotation. It steers the deserializer's bit-slip until control tokens are seen consistently, then decodes each word into DE, the two control bits and the 8-bit pixel byte. One instance is used per lane. The blue lane's O_ctrl carries {VS, HS}.

## Interface
- SEARCH_WINDOW, 4096: cycles without a control token before the block slips (unlocked) or drops lock (locked). Must exceed the longest active-video run.
- TOKEN_RUN, 16: number of consecutive control tokens needed to declare lock.
- SLIP_SETTLE, 8: idle cycles after each bit-slip pulse, allowing the deserializer output to settle.

- I_rgb_clk, input, 1: pixel clock; all logic is in this domain.
- I_rst_n, input, 1: reset, asynchronous, active-low.
- I_raw_word, input, 10: deserialized word; bit 0 is the first bit received.
- O_bitslip, output, 1: one-cycle pulse to the deserializer CALIB input.
- O_locked, output, 1: alignment achieved.
- O_de, output, 1: data-enable, decoded.
- O_ctrl, output, 2: {c1, c0}, decoded.
- O_data, output, 8: decoded pixel byte.

## Operation
- **Token detection** compares the full word I_raw_word[9:0]:
  - 10'b1101010100 gives ctrl 00
  - 10'b0010101011 gives ctrl 01
  - 10'b0101010100 gives ctrl 10
  - 10'b1010101011 gives ctrl 11
  - Any other word is a data word.
- **Data decode**:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- **FSM states**: SEARCH, SLIP, SETTLE, LOCKED.
- **Counters**:
  - gap_cnt counts cycles since the last token and saturates at SEARCH_WINDOW.
  - run_cnt counts consecutive tokens and saturates at TOKEN_RUN.
- **SEARCH**:
  - A token increments run_cnt and clears gap_cnt; a non-token clears run_cnt.
  - run_cnt reaching TOKEN_RUN moves to LOCKED.
  - gap_cnt reaching SEARCH_WINDOW moves to SLIP.
- **SLIP**: O_bitslip=1 for exactly one cycle, then SETTLE. run_cnt and gap_cnt are cleared.
- **SETTLE**: waits SLIP_SETTLE cycles, ignoring input, then SEARCH.
- **LOCKED**:
  - A token clears gap_cnt.
  - gap_cnt reaching SEARCH_WINDOW drops to SEARCH with O_locked=0.
  - Invalid data words are not checked.
- **Slip wrap**: slips repeat without limit. After 10 slips the rotation wraps naturally, and the block keeps cycling.
- **Output gating**:
  - While not LOCKED: O_de=0, O_ctrl=2'b00, O_data=8'h00.
  - While LOCKED, a token gives O_de=0, O_ctrl=token value, O_data=8'h00.
  - While LOCKED, a data word gives O_de=1, O_data=decoded byte, and O_ctrl holds its last control value.
- **Simultaneous events**: if a token arrives on the same cycle gap_cnt would reach SEARCH_WINDOW, the token wins (gap_cnt clears, no slip or lock loss).

## Timing
- **Reset values**: all outputs 0, FSM in SEARCH, counters 0, internal registers 0.
- **Pipeline**: 2 stages. Stage 1 registers I_raw_word and the token flag; stage 2 registers the decoded outputs.
- **Latency**: 2 cycles from I_raw_word to O_de/O_ctrl/O_data.
- **O_locked** rises on the cycle after the TOKEN_RUN-th consecutive token is registered, so the first gated output appears on that cycle.
- **O_bitslip** pulses are separated by at least SEARCH_WINDOW + SLIP_SETTLE + 1 cycles.
- **Reset mid-operation**: returns to SEARCH immediately. A pending O_bitslip is cancelled and the pipeline contents are discarded.

## Structure
- Shared package `dvi_pkg` holds:
  - the four control-token constants;
  - the FSM state encoding;
  - default values of the three parameters.
- The team's TMDS encoder uses the same token constants from `dvi_pkg`.
- One natural sub-module: `tmds_word_decode`, combinational, producing {is_token, ctrl, data} from a 10-bit word. The FSM and pipeline stay in `dvi_decoder`.

## Test plan
- **Reset**: assert I_rst_n=0 mid-stream → all outputs 0 on the next edge; FSM back in SEARCH.
- **Aligned stream**: 20× 10'b1101010100, then 10'b0100000000 → O_locked=1 after the 16th token. The data word yields O_de=1, O_data=8'h00, O_ctrl=00 two cycles later.
- **Decode sweep**: encoder output for 0x00..0xFF with disparity history → each byte reproduced exactly, 2-cycle latency.
- **Bit-slip**: a bench deserializer model starts at rotation 3 and reduces rotation by one per O_bitslip, with a tokens-only input → exactly 3 O_bitslip pulses, each ≥ SEARCH_WINDOW+SLIP_SETTLE+1 apart, then O_locked=1.
- **Lock loss**: after lock, feed SEARCH_WINDOW consecutive data words → O_locked falls, outputs gate to 0, and the next O_bitslip follows SEARCH_WINDOW cycles later.
- **Control tracking**: tokens 10'b0010101011 then 10'b1010101011 → O_ctrl 01 then 11. O_ctrl holds 11 through the following data words.
